rr_mux_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a 16:1 select mux; shares one output channel among 16 requesters.
- Picks a requester, drives the mux select, and streams that requester's data under a valid/ready handshake.
- Releases the grant after a bounded number of beats, so no requester can starve the others.
- Sits between 16 producer lanes and a single downstream consumer.

---
 rtl/rr_arb_pkg.sv | 32 +++
 rtl/mux16_w.sv | 15 +
 rtl/rr_mux_arbiter.sv | 109 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared constants, FSM state type and circular priority search for rr_mux_arbiter.
package rr_arb_pkg;
  localparam int N            = 16;
  localparam int SELW         = 4;
  localparam int MAX_HOLD_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic            found;
    logic [SELW-1:0] idx;
  } pick_t;

  // First set bit of req walking ptr, ptr+1, ... with wrap.
  // The loop walks from the far end so the nearest hit is written last.
  function automatic pick_t rr_pick(input logic [N-1:0] req, input logic [SELW-1:0] ptr);
    pick_t           r;
    logic [SELW-1:0] lane;
    r = '0;
    for (int i = N-1; i >= 0; i--) begin
      lane = ptr + SELW'(i);
      if (req[lane]) begin
        r.found = 1'b1;
        r.idx   = lane;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/mux16_w.sv
// W-bit 16:1 select mux, purely combinational.
module mux16_w
  import rr_arb_pkg::*;
#(
  parameter int W = 1
) (
  input  logic [N*W-1:0]  x,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    y
);
  logic [N-1:0][W-1:0] w_lane;

  assign w_lane = x;
  assign y      = w_lane[sel];
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sequencing 16 lanes onto one valid/ready channel with a per-grant beat cap.
// Optional RR_ARB_LOCK_EN adds a lock input that suspends the beat cap while high.
module rr_mux_arbiter
  import rr_arb_pkg::*;
#(
  parameter int W        = 1,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  x,
  input  logic            ready,
  output logic            valid,
  output logic [W-1:0]    y,
  output logic [SELW-1:0] sel,
  output logic [N-1:0]    gnt,
  output logic            busy
`ifdef RR_ARB_LOCK_EN
  ,
  input  logic            lock
`endif
);
  localparam int            HW        = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  state_t          r_state;
  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] r_sel;
  logic [HW-1:0]   r_hold;

  logic            w_grant;
  logic            w_valid;
  logic            w_xfer;
  logic            w_cap;
  logic            w_last;
  logic            w_release;
  logic [SELW-1:0] w_next_ptr;
  pick_t           w_pick_idle;
  pick_t           w_pick_rel;
  logic [N-1:0]    w_onehot;

`ifdef RR_ARB_LOCK_EN
  assign w_cap = ~lock;
`else
  assign w_cap = 1'b1;
`endif

  assign w_grant    = (r_state == GRANT);
  assign w_valid    = w_grant & req[r_sel];
  assign w_xfer     = w_valid & ready;
  assign w_last     = w_xfer & w_cap & (r_hold == HOLD_LAST);
  // A req drop and a final beat on the same edge are one release.
  assign w_release  = w_grant & (~req[r_sel] | w_last);
  assign w_next_ptr = r_sel + SELW'(1);

  assign w_pick_idle = rr_pick(req, r_ptr);
  assign w_pick_rel  = rr_pick(req, w_next_ptr);

  always_comb begin
    w_onehot        = '0;
    w_onehot[r_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_idle.found) begin
            r_sel   <= w_pick_idle.idx;
            r_hold  <= '0;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_ptr <= w_next_ptr;
            if (w_pick_rel.found) begin
              r_sel  <= w_pick_rel.idx;
              r_hold <= '0;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_xfer && (r_hold != HOLD_LAST)) begin
            // Saturates at HOLD_LAST, which only matters while lock holds the grant.
            r_hold <= r_hold + HW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign valid = w_valid;
  assign busy  = w_grant;
  assign sel   = r_sel;
  assign gnt   = w_grant ? w_onehot : '0;

  mux16_w #(.W(W)) u_ymux (
    .x   (x),
    .sel (r_sel),
    .y   (y)
  );
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: per-cycle reference model plus literal checkpoints.
module tb_rr_mux_arbiter;
  localparam int NL = 16;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NL-1:0] req = '0;
  logic [NL-1:0] x   = '0;
  logic          ready = 1'b0;
  logic          valid;
  logic [0:0]    y;
  logic [3:0]    sel;
  logic [NL-1:0] gnt;
  logic          busy;
`ifdef RR_ARB_LOCK_EN
  logic          lock = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  rr_mux_arbiter #(.W(1), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .x     (x),
    .ready (ready),
    .valid (valid),
    .y     (y),
    .sel   (sel),
    .gnt   (gnt),
    .busy  (busy)
`ifdef RR_ARB_LOCK_EN
    ,
    .lock  (lock)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: who holds the channel, how many beats it has moved,
  // and where the next search starts.
  bit m_busy  = 1'b0;
  int m_sel   = 0;
  int m_ptr   = 0;
  int m_beats = 0;

  function automatic int pick(input logic [NL-1:0] r, input int start);
    for (int k = 0; k < NL; k++)
      if (r[(start + k) % NL]) return (start + k) % NL;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int  win, beats, nsel, nptr;
    bit  moved, rel, nbusy, capped;
    if (rst) begin
      m_busy  <= 1'b0;
      m_sel   <= 0;
      m_ptr   <= 0;
      m_beats <= 0;
    end else begin
      nbusy = m_busy; nsel = m_sel; nptr = m_ptr; beats = m_beats;
      capped = 1'b1;
`ifdef RR_ARB_LOCK_EN
      capped = !lock;
`endif
      if (!m_busy) begin
        win = pick(req, m_ptr);
        if (win >= 0) begin nbusy = 1'b1; nsel = win; beats = 0; end
      end else begin
        moved = req[m_sel] && ready;
        if (moved) beats = beats + 1;
        rel = !req[m_sel] || (moved && capped && beats >= MH);
        if (rel) begin
          nptr = (m_sel + 1) % NL;
          win  = pick(req, nptr);
          if (win >= 0) begin nsel = win; beats = 0; end
          else nbusy = 1'b0;
        end
      end
      m_busy <= nbusy; m_sel <= nsel; m_ptr <= nptr; m_beats <= beats;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every negative edge the outputs must match the model.
  always @(negedge clk) begin
    logic [NL-1:0] eg;
    eg = m_busy ? (NL'(1) << m_sel) : '0;
    chk("model_gnt",   32'(gnt),   32'(eg));
    chk("model_valid", 32'(valid), 32'(m_busy && req[m_sel]));
    chk("model_sel",   32'(sel),   32'(m_sel));
    chk("model_busy",  32'(busy),  32'(m_busy));
    chk("model_y",     32'(y),     32'(x[m_sel]));
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (ready) x = NL'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    x = NL'($urandom);
    // Reset with all lanes requesting.
    req = 16'hFFFF; ready = 1'b1;
    step(); step();
    chk("rst_gnt",   32'(gnt),   32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_sel",   32'(sel),   32'h0);
    rst = 1'b0;
    step();
    chk("first_sel", 32'(sel), 32'h0);
    chk("first_gnt", 32'(gnt), 32'h0001);

    // Single requester: re-granted with no idle bubble.
    do_reset();
    req = 16'h0020; ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("solo_sel",  32'(sel),  32'd5);
      chk("solo_busy", 32'(busy), 32'd1);
    end

    // Lanes 0 and 15: 4 beats each, pointer wraps 15 -> 0.
    do_reset();
    req = 16'h8001; ready = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("wrap_sel", 32'(sel), (k >= 5 && k <= 8) ? 32'd15 : 32'd0);
    end

    // Backpressure on lane 3, then 4 beats before handing to lane 4.
    do_reset();
    req = 16'h0008; ready = 1'b0;
    step();
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_valid", 32'(valid), 32'd1);
      chk("bp_sel",   32'(sel),   32'd3);
    end
    ready = 1'b1; req = 16'h0018;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("bp_release_sel", 32'(sel), (k == 4) ? 32'd4 : 32'd3);
    end

    // Lane 7 drops after 2 beats; lane 9 takes over.
    do_reset();
    req = 16'h0280; ready = 1'b1;
    step();
    chk("drop_sel7", 32'(sel), 32'd7);
    step(); step();
    req = 16'h0200;
    #1;
    chk("drop_valid_now", 32'(valid), 32'd0);
    step();
    chk("drop_sel9", 32'(sel), 32'd9);
    chk("drop_gnt9", 32'(gnt), 32'h0200);

    // Async reset mid-grant (lane 12, second grant, 2 beats in).
    do_reset();
    req = 16'h1000; ready = 1'b1;
    for (int k = 0; k < 7; k++) step();
    chk("mid_sel12", 32'(sel), 32'd12);
    rst = 1'b1;
    #1;
    chk("mid_rst_gnt",   32'(gnt),   32'h0);
    chk("mid_rst_valid", 32'(valid), 32'h0);
    step();
    rst = 1'b0;
    req = 16'h5000;
    step();
    chk("restart_ptr0_sel", 32'(sel), 32'd12);

`ifdef RR_ARB_LOCK_EN
    // Lock keeps lane 12 past the beat cap until it drops req.
    do_reset();
    lock = 1'b1; req = 16'h5000; ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("lock_sel12", 32'(sel), 32'd12);
    end
    req = 16'h4000;
    step();
    chk("lock_sel14", 32'(sel), 32'd14);
    lock = 1'b0;
`endif

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
